// File: rtl/pwm_bank.sv
// pwm_bank: multi-channel PWM generator driven by byte writes from the SPI
// register peripheral. Each channel has a shadow duty that is committed to
// its active duty only at a period boundary, so outputs never glitch
// mid-period. A programmable prescaler stretches every period step.
//
// Optional feature macro: PWM_BANK_CENTER_ALIGN_EN
//   defined   -> control bit 0 selects centre-aligned (triangle) compare
//   undefined -> edge-aligned only, control writes are ignored
//
// Write port: wr_en is a single-cycle strobe with no back-pressure; every
// cycle with wr_en high is exactly one accepted write of wr_data to wr_addr.

module pwm_bank #(
  parameter int NUM_CH = 16,
  parameter int CNT_W  = 8,
  parameter int PRE_W  = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [6:0]        wr_addr,
  input  logic [7:0]        wr_data,
  output logic [NUM_CH-1:0] out,
  output logic              period_start
);

  // Last value of the period counter (M-1 with M = 2^CNT_W - 1)
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << CNT_W) - 2);

  logic [NUM_CH-1:0] out_en;
  logic [NUM_CH-1:0] pwm_en;
  logic [NUM_CH-1:0] out_en_nxt;
  logic [NUM_CH-1:0] pwm_en_nxt;
  logic [NUM_CH-1:0] out_nxt;
  logic [PRE_W-1:0]  prescale;
  logic [PRE_W-1:0]  prescale_nxt;
  logic [PRE_W-1:0]  pcnt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cmp;
  logic [CNT_W-1:0]  shadow [NUM_CH];
  logic [CNT_W-1:0]  active [NUM_CH];
  logic              tick;
  logic              wrap;

  // A tick ends each prescaler interval; >= makes a shrinking prescale tick at once
  assign tick = (pcnt >= prescale);
  // The boundary tick is the one that takes cnt from its last value back to 0
  assign wrap = tick && (cnt == CNT_LAST);

  // Decode byte writes to enable and prescale registers; bits past NUM_CH do not exist
  always_comb begin
    out_en_nxt   = out_en;
    pwm_en_nxt   = pwm_en;
    prescale_nxt = prescale;
    if (wr_en) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (wr_addr == 7'(ch / 8))
          out_en_nxt[ch] = wr_data[3'(ch)];
        if (wr_addr == 7'(16 + ch / 8))
          pwm_en_nxt[ch] = wr_data[3'(ch)];
      end
      for (int b = 0; b < PRE_W; b++) begin
        if (b < 8) begin
          if (wr_addr == 7'h20)
            prescale_nxt[b] = wr_data[3'(b)];
        end else if (wr_addr == 7'h21) begin
          prescale_nxt[b] = wr_data[3'(b)];
        end
      end
    end
  end

`ifdef PWM_BANK_CENTER_ALIGN_EN
  localparam int               TRI_W    = CNT_W - 1;
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(1 << (CNT_W - 1));

  logic             ctrl_center;
  logic             mode_center;
  logic [TRI_W-1:0] tri_val;

  // Triangle rises over the first half and folds back over the second; the
  // compare is mirrored and doubled so it is smallest at mid-period and the
  // full duty range still maps onto 0..M-1
  always_comb begin
    tri_val = (cnt < CNT_HALF) ? cnt[TRI_W-1:0] : TRI_W'(CNT_LAST - cnt);
    cmp     = mode_center ? (CNT_LAST - {tri_val, 1'b0}) : cnt;
  end

  // Mode register is written any time; the mode in use only changes at a boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_center <= 1'b0;
      mode_center <= 1'b0;
    end else begin
      if (wr_en && (wr_addr == 7'h30))
        ctrl_center <= wr_data[0];
      if (wrap)
        mode_center <= ctrl_center;
    end
  end
`else
  // Edge-aligned compare only
  assign cmp = cnt;
`endif

  // Per-channel next output: disabled low, static high, or PWM compare
  always_comb begin
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (!out_en[ch])
        out_nxt[ch] = 1'b0;
      else if (!pwm_en[ch])
        out_nxt[ch] = 1'b1;
      else
        out_nxt[ch] = (cmp < active[ch]);
    end
  end

  // Prescaler and period counter
  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt <= '0;
      cnt  <= '0;
    end else begin
      if (tick) begin
        pcnt <= '0;
        cnt  <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
      end else begin
        pcnt <= pcnt + 1'b1;
      end
    end
  end

  // Enable and prescale registers take writes immediately
  always_ff @(posedge clk) begin
    if (rst) begin
      out_en   <= '0;
      pwm_en   <= '0;
      prescale <= '0;
    end else begin
      out_en   <= out_en_nxt;
      pwm_en   <= pwm_en_nxt;
      prescale <= prescale_nxt;
    end
  end

  // Shadow duties take writes; active duties copy the old shadow at a boundary,
  // so a write landing on the boundary cycle waits one more period
  always_ff @(posedge clk) begin
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (rst) begin
        shadow[ch] <= '0;
        active[ch] <= '0;
      end else begin
        if (wrap)
          active[ch] <= shadow[ch];
        if (wr_en && (wr_addr == 7'(64 + ch)))
          shadow[ch] <= wr_data[CNT_W-1:0];
      end
    end
  end

  // Registered outputs; period_start marks the commit
  always_ff @(posedge clk) begin
    if (rst) begin
      out          <= '0;
      period_start <= 1'b0;
    end else begin
      out          <= out_nxt;
      period_start <= wrap;
    end
  end

endmodule
